// File: rtl/sram_responder.sv
// Single-clock SRAM responder for the core's instruction and data ports: clears storage after reset,
// then serves 1-cycle reads and byte writes. Define SRAM_RAW_BYPASS_EN to forward same-cycle data writes to the instruction read.
module sram_responder #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] clr_cnt;
    logic [31:0]          mem [DEPTH];

    logic [31:0]          inst_off, data_off;
    logic [ADDR_BITS-1:0] inst_idx, data_idx;
    logic                 inst_inr, data_inr, inst_mis, data_mis;
    logic                 inst_rd, data_rd, data_wr, raw_hit, err_next;
    logic [31:0]          inst_word, data_word, merged, inst_next;
    logic                 unused_inst_wdata;

    assign unused_inst_wdata = ^inst_sram_wdata;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign inst_off = inst_sram_addr - BASE_ADDR;
    assign data_off = data_sram_addr - BASE_ADDR;
    assign inst_idx = inst_off[ADDR_BITS+1:2];
    assign data_idx = data_off[ADDR_BITS+1:2];
    assign inst_inr = (inst_off[31:ADDR_BITS+2] == '0);
    assign data_inr = (data_off[31:ADDR_BITS+2] == '0);
    assign inst_mis = |inst_off[1:0];
    assign data_mis = |data_off[1:0];

    assign inst_rd  = (state == RUN) && inst_sram_en;
    assign data_rd  = (state == RUN) && data_sram_en;
    assign data_wr  = data_rd && data_inr && (|data_sram_wen);
    assign raw_hit  = inst_rd && inst_inr && data_wr && (inst_idx == data_idx);

    assign inst_word = mem[inst_idx];
    assign data_word = mem[data_idx];

    always_comb begin
        merged = data_word;
        for (int b = 0; b < 4; b++) begin
            if (data_sram_wen[b]) merged[8*b +: 8] = data_sram_wdata[8*b +: 8];
        end
    end

`ifdef SRAM_RAW_BYPASS_EN
    assign inst_next = raw_hit ? merged : inst_word;
`else
    assign inst_next = inst_word;
    logic unused_raw_hit;
    assign unused_raw_hit = raw_hit;
`endif

    assign err_next = (inst_rd && ((|inst_sram_wen) || inst_mis || !inst_inr)) ||
                      (data_rd && (data_mis || !data_inr));

    // Storage carries no reset; CLEAR sweeps it to zero one word per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (data_wr) begin
            mem[data_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= CLEAR;
            clr_cnt         <= '0;
            init_done       <= 1'b0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
            addr_err        <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (inst_sram_en) inst_sram_rdata <= inst_inr ? inst_next : 32'h0;
                    if (data_sram_en) data_sram_rdata <= data_inr ? data_word : 32'h0;
                    if (err_next)     addr_err        <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (ADDR_BITS=4, nonzero base): a driver pushes model expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_sram_responder;

    localparam int          AB    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = 4'h0;
    logic [31:0] inst_sram_addr = 32'h0;
    logic [31:0] inst_sram_wdata = 32'h0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        init_done;
    logic        addr_err;

    sram_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .init_done(init_done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
        logic        done;
        logic        err;
        bit          chk_inst;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_inst, m_data;
    logic        m_err;
    bit          m_inst_known;
    int          m_edges;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, req);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("data_rdata", mon_e.id, data_sram_rdata, mon_e.data);
            check("init_done", mon_e.id, {31'h0, init_done}, {31'h0, mon_e.done});
            check("addr_err", mon_e.id, {31'h0, addr_err}, {31'h0, mon_e.err});
            if (mon_e.chk_inst) check("inst_rdata", mon_e.id, inst_sram_rdata, mon_e.inst);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_inst = 32'h0;
        m_data = 32'h0;
        m_err = 1'b0;
        m_inst_known = 1'b1;
        m_edges = 0;
    endtask

    // One clock: drive at the falling edge, predict what the next rising edge produces.
    task automatic step(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                        input logic de, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd);
        exp_t        e;
        logic [31:0] ioff, doff, newv, oldi;
        int          iidx, didx;
        @(negedge clk);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = $urandom;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        step_no++;
        if (m_edges < DEPTH) begin
            m_edges++;
        end else begin
            ioff = ia - BASE;
            doff = da - BASE;
            iidx = int'(ioff >> 2);
            didx = int'(doff >> 2);
            oldi = (ioff < SPAN) ? m_mem[iidx] : 32'h0;
            if (de) begin
                if (doff % 4 != 0) m_err = 1'b1;
                if (doff < SPAN) begin
                    m_data = m_mem[didx];
                    newv = m_mem[didx];
                    for (int b = 0; b < 4; b++) if (dw[b]) newv[8*b +: 8] = dd[8*b +: 8];
                    m_mem[didx] = newv;
                end else begin
                    m_data = 32'h0;
                    m_err = 1'b1;
                end
            end
            if (ie) begin
                m_inst_known = (iw == 4'h0);
                if (iw != 4'h0 || ioff % 4 != 0) m_err = 1'b1;
                if (ioff < SPAN) begin
`ifdef SRAM_RAW_BYPASS_EN
                    m_inst = m_mem[iidx];
`else
                    m_inst = oldi;
`endif
                end else begin
                    m_inst = 32'h0;
                    m_err = 1'b1;
                end
            end
        end
        e.inst = m_inst;
        e.data = m_data;
        e.done = (m_edges >= DEPTH);
        e.err = m_err;
        e.chk_inst = m_inst_known;
        e.id = step_no;
        sbq.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, BASE, 1'b0, 4'h0, BASE, 32'h0);
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases just after a rising edge.
    task automatic do_reset(input int hold);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_inst_rdata", step_no, inst_sram_rdata, 32'h0);
        check("rst_data_rdata", step_no, data_sram_rdata, 32'h0);
        check("rst_init_done", step_no, {31'h0, init_done}, 32'h0);
        check("rst_addr_err", step_no, {31'h0, addr_err}, 32'h0);
        model_reset();
        repeat (hold) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] legal_addr();
        return BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
    endfunction

    function automatic logic [31:0] any_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return legal_addr();
        if (sel == 7) return legal_addr() + 32'($urandom_range(1, 3));
        if (sel == 8) return BASE + SPAN + 32'($urandom_range(0, 255));
        return BASE - 32'($urandom_range(1, 64));
    endfunction

    function automatic logic [3:0] rand_wen();
        return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    initial begin
        model_reset();
        do_reset(2);

        // Clearing: requests are ignored, init_done rises on the 16th edge.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h4, $urandom);
        step(1'b1, 4'h0, BASE, 1'b1, 4'h0, BASE + 32'h4, 32'h0);

        // Byte-enable write, read-first return.
        step(1'b0, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h8, 32'hDEAD_BEEF);
        step(1'b0, 4'h0, BASE, 1'b1, 4'h2, BASE + 32'h8, 32'h0000_5500);
        step(1'b0, 4'h0, BASE, 1'b1, 4'h0, BASE + 32'h8, 32'h0);

        // Same-cycle instruction read and data write to one word.
        step(1'b1, 4'h0, BASE + 32'h8, 1'b1, 4'hF, BASE + 32'h8, 32'h1234_5678);
        step(1'b1, 4'h0, BASE + 32'h8, 1'b0, 4'h0, BASE, 32'h0);
        step(1'b1, 4'h0, BASE + 32'h8, 1'b1, 4'h5, BASE + 32'h8, 32'hAABB_CCDD);
        idle();

        // Legal traffic only: addr_err must stay low.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 4'h0, legal_addr(),
                 1'($urandom_range(0, 1)), rand_wen(), legal_addr(), $urandom);

        // Reset mid-clear, then a full clear; all words read back zero.
        do_reset(2);
        for (int i = 0; i < 7; i++) step(1'b1, 4'h0, BASE, 1'b0, 4'h0, BASE, 32'h0);
        do_reset(3);
        for (int i = 0; i < DEPTH; i++) idle();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 4'h0, BASE + 32'(4 * i), 1'b1, 4'h0, BASE + 32'(4 * (DEPTH - 1 - i)), 32'h0);

        // Out-of-range and misaligned accesses.
        step(1'b0, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h4, 32'hCAFE_F00D);
        step(1'b0, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h40, 32'h5555_5555);
        step(1'b0, 4'h0, BASE, 1'b1, 4'h0, BASE + 32'h0, 32'h0);
        step(1'b1, 4'h0, BASE + 32'h4, 1'b1, 4'h0, BASE + 32'h5, 32'h0);
        step(1'b0, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h10, 32'h0BAD_CAFE);
        step(1'b0, 4'h0, BASE, 1'b1, 4'h0, BASE + 32'h10, 32'h0);

        // Reset in RUN after writes; storage is cleared again.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) idle();
        step(1'b1, 4'h0, BASE + 32'h4, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
        step(1'b1, 4'h1, BASE + 32'hC, 1'b0, 4'h0, BASE, 32'h0);
        step(1'b1, 4'h0, BASE + 32'hC, 1'b1, 4'h0, BASE + 32'hC, 32'h0);

        // Unrestricted randomized traffic.
        step(1'b0, 4'h0, BASE, 1'b1, 4'hF, BASE + 32'h20, 32'h7777_1111);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, any_addr(),
                 1'($urandom_range(0, 1)), rand_wen(), any_addr(), $urandom);
        step(1'b1, 4'h0, BASE, 1'b1, 4'h0, BASE, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", step_no, 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the core's instruction and data SRAM ports. It accepts the `en`/`wen`/`addr`/`wdata` requests the core issues and returns `rdata` with a fixed one-cycle latency. It clears its storage after reset and flags out-of-range or misaligned accesses. It sits in the SoC between the core top level and on-chip storage, standing in for the inst/data RAMs in simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_BITS`, default 12: word-index width; depth = 2^ADDR_BITS words of 32 bits.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_sram_en` input 1: instruction read request.
- `inst_sram_wen` input 4: must be 4'b0000; any nonzero value in an enabled cycle sets `addr_err`, and no write occurs.
- `inst_sram_addr` input 32: instruction byte address.
- `inst_sram_wdata` input 32: ignored.
- `inst_sram_rdata` output 32: instruction read data.
- `data_sram_en` input 1: data access request.
- `data_sram_wen` input 4: per-byte write enables; bit i covers bits [8i+7:8i].
- `data_sram_addr` input 32: data byte address.
- `data_sram_wdata` input 32: write data.
- `data_sram_rdata` output 32: data read data.
- `init_done` output 1: high once storage clearing is complete.
- `addr_err` output 1: sticky error flag, cleared only by reset.

## Operation
- Address decode: `off = addr - BASE_ADDR`, computed modulo 2^32. Word index is `off[ADDR_BITS+1:2]`.
- In range: `off[31:ADDR_BITS+2] == 0`.
- Misaligned: `off[1:0] != 0`. The low bits are ignored for the access itself, but an enabled misaligned access sets `addr_err`.
- State machine, CLEAR and RUN:
  - Reset enters CLEAR with the clear counter at 0.
  - In CLEAR, each cycle writes 32'h0 to word[counter] and then increments the counter.
  - After word 2^ADDR_BITS-1 is written, the FSM moves to RUN and `init_done` goes to 1.
  - RUN is held until reset.
- In CLEAR, all port requests are dropped: no write, `rdata` stays at its current value (0 after reset), and `addr_err` is not updated.
- RUN, instruction port, `en=1`: reads the addressed word. `inst_sram_rdata` takes the value on the next edge.
- RUN, data port:
  - `en=1, wen=0`: read.
  - `en=1, wen!=0`: write-first is not used. Only the enabled bytes are written, and `data_sram_rdata` returns the word's pre-write contents (read-first).
- `en=0` on either port: that port's `rdata` holds its previous value.
- Out-of-range access: write dropped, `rdata` returns 32'h0, `addr_err` set.
- Same-cycle instruction read and data write to the same word: behaviour is set by the macro (see Configuration).
- Data port reads from the two ports never conflict; both are served in the same cycle.

## Timing
- Reset values: `inst_sram_rdata=0`, `data_sram_rdata=0`, `init_done=0`, `addr_err=0`, FSM=CLEAR, counter=0.
- Read latency is exactly 1 cycle, with no stalls: a request at edge N produces `rdata` valid after edge N+1.
- Write latency: bytes are visible to any read sampled on the next edge or later.
- Clear duration: 2^ADDR_BITS edges after `resetn` deasserts; `init_done` rises on edge 2^ADDR_BITS.
- Reset asserted mid-CLEAR or mid-RUN: all outputs return to reset values immediately (asynchronously). Clearing restarts from word 0 after release.
- `addr_err` sets on the edge that samples the offending request and stays set until reset.

## Configuration
- `SRAM_RAW_BYPASS_EN` defined: when an instruction-port read and a data-port write target the same in-range word in the same cycle, `inst_sram_rdata` returns the merged word (new bytes where `wen` is set, old bytes elsewhere).
- `SRAM_RAW_BYPASS_EN` undefined: `inst_sram_rdata` returns the pre-write word. The data port is read-first in both builds.

## Test plan
- Reset with ADDR_BITS=4, release, hold `inst_sram_en=1` at addr 0 -> `init_done` rises after 16 edges; requests are ignored during clearing; the first RUN read returns 32'h0; `addr_err` stays 0.
- Data write of 32'hDEADBEEF to 0x8 with `wen=4'b1111`, then `wen=4'b0010` with wdata 32'h0000_5500 -> the write cycle returns the old data; a subsequent read returns 32'hDEAD55EF.
- Instruction read at 0x8 in the same cycle as a data write of 32'h12345678 to 0x8 -> 32'h12345678 when `SRAM_RAW_BYPASS_EN` is defined, the prior word otherwise; the next instruction read returns 32'h12345678 in both builds.
- Data read at BASE_ADDR+0x40 with ADDR_BITS=4 -> `rdata=0`, `addr_err=1`; memory is unchanged; the flag stays set through later legal accesses.
- Data read at 0x5 -> returns word 1 and sets `addr_err`. Separately, an enabled instruction request with `inst_sram_wen=4'b0001` -> no write and `addr_err=1`.
- Assert `resetn=0` midway through CLEAR, and again after writes in RUN -> outputs return to 0 asynchronously; clearing restarts and the full duration elapses; previously written words read back 0.
